// File: rtl/semaforo_param_ctrl.sv
// semaforo_param_ctrl: two-road traffic-light FSM with pedestrian green clip and multiplexed 7-seg countdown.
// Define NIGHT_FLASH_EN to add the night input and the flashing-yellow FLASH state.
module semaforo_param_ctrl #(
   parameter int CLK_HZ      = 100000000,
   parameter int REFRESH_DIV = 100000,
   parameter int N_DIGITS    = 2,
   parameter int GREEN_A_S   = 20,
   parameter int GREEN_B_S   = 10,
   parameter int YELLOW_S    = 5,
   parameter int ALLRED_S    = 2,
   parameter int MIN_GREEN_S = 3
) (
   input  logic       CLK100MHZ,
   input  logic       CPU_RESETN,
   input  logic       ped_req,
   input  logic       hold,
`ifdef NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic [2:0] light_a,
   output logic [2:0] light_b,
   output logic [2:0] phase,
   output logic       sec_tick,
   output logic [7:0] AN,
   output logic [6:0] display
);
   typedef enum logic [2:0] {
      ALLRED_A = 3'd0, GREEN_A = 3'd1, YELLOW_A = 3'd2,
      ALLRED_B = 3'd3, GREEN_B = 3'd4, YELLOW_B = 3'd5
`ifdef NIGHT_FLASH_EN
      , FLASH = 3'd6
`endif
   } state_t;

   function automatic int imax(input int a, input int b);
      return a > b ? a : b;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'b0000001;
         4'd1: seg7 = 7'b1001111;
         4'd2: seg7 = 7'b0010010;
         4'd3: seg7 = 7'b0000110;
         4'd4: seg7 = 7'b1001100;
         4'd5: seg7 = 7'b0100100;
         4'd6: seg7 = 7'b0100000;
         4'd7: seg7 = 7'b0001111;
         4'd8: seg7 = 7'b0000000;
         4'd9: seg7 = 7'b0000100;
         default: seg7 = 7'b1111110;
      endcase
   endfunction

   localparam int MAXD = imax(imax(imax(GREEN_A_S, GREEN_B_S), imax(YELLOW_S, ALLRED_S)), MIN_GREEN_S);
   localparam int RW = $clog2(MAXD + 1);
   localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
   localparam int FW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int SW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   localparam int unsigned DMAX = 10 ** N_DIGITS - 1;
   localparam logic [RW-1:0] MIN_R = RW'(MIN_GREEN_S);
   localparam logic [6:0] DASH = 7'b1111110;
   localparam logic [6:0] SEG_RST = ALLRED_S > DMAX ? DASH : seg7(4'(ALLRED_S % 10));

   function automatic logic is_green(input state_t s);
      return s == GREEN_A || s == GREEN_B;
   endfunction

   function automatic logic [RW-1:0] dur(input state_t s);
      return RW'(s == GREEN_A ? GREEN_A_S : s == GREEN_B ? GREEN_B_S :
                 (s == YELLOW_A || s == YELLOW_B) ? YELLOW_S : ALLRED_S);
   endfunction

   state_t        state_q, state_d;
   logic [RW-1:0] remain_q, remain_d;
   logic          pend_q, pend_d;
   logic [PW-1:0] presc_q;
   logic [FW-1:0] ref_q;
   logic [SW-1:0] scan_q;
   logic [2:0]    lamp_a_d, lamp_b_d, lamp_a_q, lamp_b_q;
   logic [7:0]    an_d, an_q;
   logic [6:0]    seg_d, seg_q;
   logic [3:0]    dig [1 << SW];
   logic          tick, adv, green, ref_wrap;

   assign tick     = presc_q == PW'(CLK_HZ - 1);
   assign adv      = tick & ~hold;
   assign green    = is_green(state_q);
   assign ref_wrap = ref_q == FW'(REFRESH_DIV - 1);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         state_q  <= ALLRED_A;
         remain_q <= RW'(ALLRED_S);
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         pend_q   <= pend_d;
      end

   // A pending request clips a running green, or shortens the next green entry.
   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      pend_d   = pend_q | ped_req;
      if (adv && remain_q == RW'(1)) begin
         state_d = state_q == YELLOW_B ? ALLRED_A : state_t'(state_q + 3'd1);
`ifdef NIGHT_FLASH_EN
         if (night && !green) state_d = FLASH;
`endif
         remain_d = dur(state_d);
         if (is_green(state_d) && pend_d) begin
            remain_d = MIN_R;
            pend_d   = 1'b0;
         end
      end else begin
         if (adv) remain_d = remain_q - RW'(1);
         if (green && pend_d) begin
            remain_d = remain_d > MIN_R ? MIN_R : remain_d;
            pend_d   = 1'b0;
         end
      end
`ifdef NIGHT_FLASH_EN
      if (night && green) begin
         state_d  = state_q == GREEN_A ? YELLOW_A : YELLOW_B;
         remain_d = RW'(YELLOW_S);
      end
      if (state_q == FLASH) begin
         state_d  = night ? FLASH : ALLRED_A;
         remain_d = night ? remain_q : RW'(ALLRED_S);
      end
`endif
   end

   for (genvar i = 0; i < (1 << SW); i++) begin : g_dig
      assign dig[i] = 4'((32'(remain_q) / (10 ** i)) % 10);
   end

`ifdef NIGHT_FLASH_EN
   logic flash_q, flash_d;
   assign flash_d = (state_q != FLASH) | (flash_q ^ tick);
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) flash_q <= 1'b1;
      else flash_q <= flash_d;
`endif

   // Lamps decode the next state so they switch on the same edge as phase.
   always_comb begin
      lamp_a_d = state_d == GREEN_A ? 3'b001 : state_d == YELLOW_A ? 3'b010 : 3'b100;
      lamp_b_d = state_d == GREEN_B ? 3'b001 : state_d == YELLOW_B ? 3'b010 : 3'b100;
      an_d     = ~(8'd1 << scan_q);
      seg_d    = 32'(remain_q) > DMAX ? DASH : seg7(dig[scan_q]);
`ifdef NIGHT_FLASH_EN
      if (state_d == FLASH) begin
         lamp_a_d = {1'b0, flash_d, 1'b0};
         lamp_b_d = {1'b0, flash_d, 1'b0};
         an_d     = 8'hFF;
      end
`endif
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
      if (!CPU_RESETN) begin
         presc_q  <= '0;
         ref_q    <= '0;
         scan_q   <= '0;
         lamp_a_q <= 3'b100;
         lamp_b_q <= 3'b100;
         an_q     <= 8'hFE;
         seg_q    <= SEG_RST;
      end else begin
         presc_q  <= tick ? '0 : presc_q + PW'(1);
         ref_q    <= ref_wrap ? '0 : ref_q + FW'(1);
         if (ref_wrap) scan_q <= scan_q == SW'(N_DIGITS - 1) ? '0 : scan_q + SW'(1);
         lamp_a_q <= lamp_a_d;
         lamp_b_q <= lamp_b_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end

   assign phase    = state_q;
   assign sec_tick = tick;
   assign light_a  = lamp_a_q;
   assign light_b  = lamp_b_q;
   assign AN       = an_q;
   assign display  = seg_q;
endmodule

// File: tb/tb_semaforo_param_ctrl.sv
// tb_semaforo_param_ctrl: directed bench with a phase-table reference model and a wide-countdown display instance.
module tb_semaforo_param_ctrl;
   localparam int CHZ = 10, RD = 2, ND = 2, GA = 4, GB = 3, Y = 2, AR = 1, MN = 1;
   localparam int DUR [6] = '{AR, GA, Y, AR, GB, Y};
   localparam int LA [6] = '{4, 1, 2, 4, 4, 4};
   localparam int LB [6] = '{4, 4, 4, 4, 1, 2};
   localparam logic [6:0] SEG_TAB [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   logic       clk, rst_n, rst2_n, ped_req, hold, sec_tick, d2_tick;
   logic [2:0] light_a, light_b, phase, d2_la, d2_lb, d2_phase;
   logic [7:0] an, d2_an;
   logic [6:0] display, d2_display;

   int  n_chk = 0, n_err = 0, g = 0, nt = 0;
   int  m_c, m_ph, m_rem, m_an, m_seg;
   bit  m_pend;

   semaforo_param_ctrl #(.CLK_HZ(CHZ), .REFRESH_DIV(RD), .N_DIGITS(ND), .GREEN_A_S(GA), .GREEN_B_S(GB),
                         .YELLOW_S(Y), .ALLRED_S(AR), .MIN_GREEN_S(MN)) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .ped_req(ped_req), .hold(hold),
      .light_a(light_a), .light_b(light_b), .phase(phase), .sec_tick(sec_tick),
      .AN(an), .display(display));

   semaforo_param_ctrl #(.CLK_HZ(2), .REFRESH_DIV(1), .N_DIGITS(2), .GREEN_A_S(123), .GREEN_B_S(3),
                         .YELLOW_S(1), .ALLRED_S(1), .MIN_GREEN_S(1)) u_disp (
      .CLK100MHZ(clk), .CPU_RESETN(rst2_n), .ped_req(1'b0), .hold(1'b0),
      .light_a(d2_la), .light_b(d2_lb), .phase(d2_phase), .sec_tick(d2_tick),
      .AN(d2_an), .display(d2_display));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int seg_of(input int r, input int i);
      return r > 10 ** ND - 1 ? int'(7'b1111110) : int'(SEG_TAB[(r / 10 ** i) % 10]);
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t edge %0d)", nm, got, exp, $time, g);
      end
   endtask

   task automatic model_reset();
      m_c = 0; m_ph = 0; m_rem = AR; m_pend = 0; m_an = 8'hFE; m_seg = seg_of(AR, 0);
   endtask

   // Reference: one second passes every CHZ cycles; phases follow the duration table.
   task automatic model_edge();
      int sc;
      bit adv, grn;
      if (!rst_n) return;
      sc = (m_c / RD) % ND;
      m_an = 255 ^ (1 << sc);
      m_seg = seg_of(m_rem, sc);
      adv = (m_c % CHZ == CHZ - 1) && !hold;
      grn = m_ph == 1 || m_ph == 4;
      if (adv && m_rem == 1) begin
         m_ph = (m_ph + 1) % 6;
         m_rem = DUR[m_ph];
         if ((m_ph == 1 || m_ph == 4) && (m_pend || ped_req)) begin
            m_rem = MN; m_pend = 0;
         end else m_pend = m_pend | ped_req;
      end else begin
         if (adv) m_rem = m_rem - 1;
         if (grn && (m_pend || ped_req)) begin
            if (m_rem > MN) m_rem = MN;
            m_pend = 0;
         end else m_pend = m_pend | ped_req;
      end
      m_c = m_c + 1;
   endtask

   task automatic compare();
      chk("phase", phase, m_ph);
      chk("light_a", light_a, LA[m_ph]);
      chk("light_b", light_b, LB[m_ph]);
      chk("sec_tick", sec_tick, (rst_n && m_c % CHZ == CHZ - 1) ? 1 : 0);
      chk("AN", an, m_an);
      chk("display", display, m_seg);
   endtask

   task automatic step(input bit pr = 1'b0, input bit hd = 1'b0);
      ped_req = pr; hold = hd;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      g++;
      compare();
      if (g == 10) chk("wide_dash", d2_display, 7'b1111110);
      if (g == 235) begin
         chk("wide7_an0", d2_an, 8'hFE);
         chk("wide7_seg7", d2_display, 7'b0001111);
      end
      if (g == 236) begin
         chk("wide7_an1", d2_an, 8'hFD);
         chk("wide7_seg0", d2_display, 7'b0000001);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      rst_n = 0; rst2_n = 0; ped_req = 0; hold = 0;
      repeat (3) @(negedge clk);
      model_reset();
      chk("rst_phase", phase, 0);
      chk("rst_la", light_a, 3'b100);
      chk("rst_lb", light_b, 3'b100);
      chk("rst_tick", sec_tick, 0);
      chk("rst_an", an, 8'hFE);
      chk("rst_disp", display, 7'b1001111);
      compare();
      rst_n = 1; rst2_n = 1;
      for (int k = 1; k <= 130; k++) begin
         step();
         if (k == 10) begin chk("t1_ph", phase, 1); chk("t1_la", light_a, 3'b001); chk("t1_lb", light_b, 3'b100); end
         if (k == 50) begin chk("t5_ph", phase, 2); chk("t5_la", light_a, 3'b010); end
         if (k == 70) chk("t7_ph", phase, 3);
         if (k == 80) begin chk("t8_ph", phase, 4); chk("t8_lb", light_b, 3'b001); chk("t8_la", light_a, 3'b100); end
         if (k == 110) begin chk("t11_ph", phase, 5); chk("t11_lb", light_b, 3'b010); end
         if (k == 130) chk("t13_ph", phase, 0);
      end
      run(10);
      chk("ga_ph", phase, 1);
      chk("ga_rem", dut.remain_q, 4);
      step(1'b1);
      chk("clip_rem", dut.remain_q, 1);
      chk("clip_model", m_rem, 1);
      chk("clip_pend", dut.pend_q, 0);
      run(9);
      chk("clip_ya", phase, 2);
      step(1'b1);
      chk("ya_pend", dut.pend_q, 1);
      run(29);
      chk("gb_short_ph", phase, 4);
      chk("gb_short_rem", dut.remain_q, 1);
      chk("gb_short_pend", dut.pend_q, 0);
      run(79);
      chk("pre_coinc_ph", phase, 1);
      step(1'b1);
      chk("coinc_ph", phase, 2);
      chk("coinc_rem", dut.remain_q, 2);
      chk("coinc_pend", dut.pend_q, 1);
      run(30);
      chk("coinc_gb_ph", phase, 4);
      chk("coinc_gb_rem", dut.remain_q, 1);
      run(110);
      chk("hold_start_ph", phase, 4);
      chk("hold_start_rem", dut.remain_q, 3);
      for (int i = 0; i < 29; i++) begin
         step(1'b0, 1'b1);
         if (sec_tick) nt++;
      end
      chk("hold_ticks", nt, 3);
      chk("hold_rem", dut.remain_q, 3);
      chk("hold_ph", phase, 4);
      step(1'b1, 1'b1);
      chk("hold_clip_rem", dut.remain_q, 1);
      chk("hold_clip_ph", phase, 4);
      run(5);
      rst_n = 0;
      model_reset();
      #1;
      chk("mid_rst_ph", phase, 0);
      chk("mid_rst_la", light_a, 3'b100);
      chk("mid_rst_lb", light_b, 3'b100);
      chk("mid_rst_an", an, 8'hFE);
      chk("mid_rst_disp", display, 7'b1001111);
      step();
      step();
      rst_n = 1;
      run(9);
      chk("first_tick", sec_tick, 1);
      chk("first_tick_ph", phase, 0);
      step();
      chk("first_tick_ga", phase, 1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
